byte_ram_responder: RTL
=======================

# byte_ram_responder

Memory-side responder for the byte-wide fetch bus used by the opcode fetch path. It accepts single-byte read/write requests (`request`, `address`), holds `ramBusy` high for a fixed access latency, and then presents the byte on `ramData` with `ramBusy` low. It sits between the opcode/operand fetch initiators and the on-chip byte memory. It also serves as the bus model in fetch-unit benches.

## Interface
- `ADDRESS_WIDTH`, 32: width of `address`.
- `DEPTH_LOG2`, 8: memory holds 2^DEPTH_LOG2 bytes.
- `LATENCY`, 2: cycles `ramBusy` stays high per access; legal range 1..15.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `request` in 1: one-cycle strobe; `address`, `write` and `writeData` are valid in the same cycle.
- `write` in 1: 1 = write `writeData`, 0 = read.
- `address` in ADDRESS_WIDTH: byte address.
- `writeData` in 8: write byte.
- `ramData` out 8: read byte, or the written byte after a write; held until the next completion.
- `ramBusy` out 1: access in flight.
- `done` out 1: one-cycle pulse in the cycle after completion.
- `overflow` out 1: sticky; set when a request is dropped.
- `addrError` out 1: sticky; present only with the macro, tied to 0 otherwise.

## Operation
- FSM has three states: IDLE, WAIT, DONE.
- **IDLE**: on `request`, latch the command into the active register, load the counter with LATENCY-1, and go to WAIT.
- **WAIT**:
  - `ramBusy`=1.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, perform the access:
    - Read: `ramData` <= mem[idx].
    - Write: mem[idx] <= `writeData`; `ramData` <= `writeData`.
  - Then go to DONE.
- **DONE**:
  - `ramBusy`=0, `done`=1 for exactly one cycle.
  - If the pending slot is valid, start it (go to WAIT, clear the slot).
  - Else if `request`, start it.
  - Else go to IDLE.
- **Pending slot** (one entry) captures a `request` that arrives in WAIT, or in DONE while the slot is already consumed.
  - In DONE with the slot valid and a new `request`: start the slot's command and store the new request in the slot.
  - A `request` that arrives while the slot is full is dropped and sets `overflow`.
- **Index**: idx = `address`[DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses wrap modulo 2^DEPTH_LOG2.
- **Serialization**: accesses are strictly in order, so there are no read/write hazards.
- **Memory contents** are not cleared by reset.
- **Reset values**: `ramData`=8'h00, `ramBusy`=0, `done`=0, `overflow`=0, `addrError`=0, FSM=IDLE, pending slot cleared.
- **Reset mid-operation**: the in-flight access and any pending access are abandoned. A write that has not reached its completion edge does not modify memory.

## Timing
- Request sampled at edge N from IDLE:
  - `ramBusy`=1 for cycles N+1 .. N+LATENCY.
  - Data is updated at edge N+LATENCY.
  - In cycle N+LATENCY+1: `ramBusy`=0, `done`=1, `ramData` valid.
- Back-to-back requests from DONE add no extra idle cycle, so the throughput is 1 byte per LATENCY+1 cycles.
- `ramData` stays stable from its completion edge until the next completion edge.

## Configuration
- `BYTE_RAM_BOUNDS_CHECK_EN` defined:
  - Any address with nonzero bits above DEPTH_LOG2-1 is out of range.
  - An out-of-range read returns 8'hFF.
  - An out-of-range write does not modify memory; `ramData` <= 8'hFF.
  - Both cases set `addrError` at the completion edge.
  - Timing is unchanged.
- Macro undefined: addresses wrap as described above and `addrError` is constant 0.

## Test plan
- Reset, then check every output is at its reset value.
- LATENCY=2: write 8'hA5 to 0x10, then read 0x10. Required: `ramBusy` high for exactly 2 cycles per access; `done` pulses; `ramData`=8'hA5.
- Fetch-style sequence: read 0x20..0x23, each issued in the DONE cycle of the previous access (preloaded 11,22,33,44). Required: 4 `done` pulses spaced 3 cycles apart, data in order, `overflow`=0.
- Issue two extra requests during WAIT. Required: the first is queued and serviced; the second is dropped, `overflow`=1 and it stays 1 until reset.
- Write 8'h5A to 0x110 with DEPTH_LOG2=8. Required:
  - Macro off: read of 0x10 returns 8'h5A.
  - Macro on: read of 0x110 returns 8'hFF, `addrError`=1, and 0x10 is unchanged.
- Assert `reset` one cycle into a write's WAIT. Required: a following read of that address returns the old byte; `ramBusy`=0 the cycle after reset.

Source files
------------

// File: rtl/byte_ram_responder_if.sv
// Byte-wide fetch bus between fetch initiators (master) and the byte RAM responder (slave).
// Handshake: request is a one-cycle strobe with write/address/writeData valid in that cycle; there
// is no ready, every strobe is accepted (started, queued or dropped with overflow), ramBusy marks an
// access in flight and done pulses for one cycle with ramData valid from that cycle on.
interface byte_ram_responder_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     request;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [7:0]               writeData;
    logic [7:0]               ramData;
    logic                     ramBusy;
    logic                     done;
    logic                     overflow;
    logic                     addrError;

    modport master (
        output request, write, address, writeData,
        input  ramData, ramBusy, done, overflow, addrError
    );

    modport slave (
        input  request, write, address, writeData,
        output ramData, ramBusy, done, overflow, addrError
    );
endinterface

// File: rtl/byte_ram_responder.sv
// Byte RAM responder: fixed-latency single-byte reads/writes with a one-entry pending slot.
// Optional BYTE_RAM_BOUNDS_CHECK_EN flags out-of-range addresses instead of wrapping them.
module byte_ram_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH_LOG2    = 8,
    parameter int LATENCY       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    byte_ram_responder_if.slave  bus,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                  wr;
`ifdef BYTE_RAM_BOUNDS_CHECK_EN
        logic                  oor;
`endif
        logic [DEPTH_LOG2-1:0] idx;
        logic [7:0]            wdata;
    } cmd_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    cmd_t       act_q;
    cmd_t       slot_q;
    logic       slot_vld_q;
    logic [7:0] rdata_q;
    logic       busy_q;
    logic       done_q;
    logic       ovf_q;
    logic       aerr_q;
    cmd_t       req_cmd;
    logic       access;
    logic       mem_we;

    logic [7:0] mem [2**DEPTH_LOG2];

    always_comb begin
        req_cmd       = '0;
        req_cmd.wr    = bus.write;
        req_cmd.idx   = bus.address[DEPTH_LOG2-1:0];
        req_cmd.wdata = bus.writeData;
`ifdef BYTE_RAM_BOUNDS_CHECK_EN
        req_cmd.oor   = |bus.address[ADDRESS_WIDTH-1:DEPTH_LOG2];
`endif
    end

    // The completion edge is the only edge that touches memory or ramData.
    assign access = (state_q == WAIT) && (cnt_q == 4'd0);
`ifdef BYTE_RAM_BOUNDS_CHECK_EN
    assign mem_we = access && act_q.wr && !act_q.oor && !reset;
`else
    assign mem_we = access && act_q.wr && !reset;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[act_q.idx] <= act_q.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_q      <= '0;
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
            rdata_q    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.request) begin
                        act_q   <= req_cmd;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.request) begin
                        if (slot_vld_q) begin
                            ovf_q <= 1'b1;
                        end else begin
                            slot_q     <= req_cmd;
                            slot_vld_q <= 1'b1;
                        end
                    end
                    if (access) begin
                        rdata_q <= act_q.wr ? act_q.wdata : mem[act_q.idx];
`ifdef BYTE_RAM_BOUNDS_CHECK_EN
                        if (act_q.oor) begin
                            rdata_q <= 8'hFF;
                            aerr_q  <= 1'b1;
                        end
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    // Queued command goes first; a fresh request then takes over the slot.
                    if (slot_vld_q) begin
                        act_q   <= slot_q;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                        if (bus.request) begin
                            slot_q <= req_cmd;
                        end else begin
                            slot_vld_q <= 1'b0;
                        end
                    end else if (bus.request) begin
                        act_q   <= req_cmd;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ramData  = rdata_q;
    assign bus.ramBusy  = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
`ifdef BYTE_RAM_BOUNDS_CHECK_EN
    assign bus.addrError = aerr_q;
`else
    assign bus.addrError = 1'b0;
`endif
    assign state_o = state_q;
endmodule
